// File: rtl/dmem_access_pkg.sv
// Shared types and widths for the dmem_access memory stage and its statistics block.
// Optional counters are enabled by defining VENUS_DMEM_STATS_EN.
package dmem_access_pkg;

    localparam int WORD  = 32;
    localparam int ADDR  = 16;
    localparam int W_RD  = 5;
    localparam int W_MOP = 2;

    typedef enum logic [1:0] {
        MOP_NONE  = 2'd0,
        MOP_LOAD  = 2'd1,
        MOP_STORE = 2'd2
    } mop_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RD     = 2'd1,
        ST_RDHOLD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SEL_IN  = 2'd0,
        SEL_Q   = 2'd1,
        SEL_BUF = 2'd2
    } out_sel_e;

    typedef struct packed {
        logic            wb;
        logic [W_RD-1:0] rd_num;
        logic [WORD-1:0] rd_data;
    } wb_payload_t;

    // The reserved op code behaves exactly like a pass-through.
    function automatic mop_e decode_mop(input logic [W_MOP-1:0] code);
        mop_e m;
        case (code)
            2'd1:    m = MOP_LOAD;
            2'd2:    m = MOP_STORE;
            default: m = MOP_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_stats.sv
// Free-running event counters for the memory stage: accepted loads, accepted stores
// and cycles in which EX was held off. Counters wrap at 2^32.
module dmem_stats
    import dmem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_inc_i,
    input  logic        st_inc_i,
    input  logic        stl_inc_i,
    output logic [31:0] ld_cnt_o,
    output logic [31:0] st_cnt_o,
    output logic [31:0] stl_cnt_o
);

    logic [31:0] ld_cnt_r;
    logic [31:0] st_cnt_r;
    logic [31:0] stl_cnt_r;

    // Event counters, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt_r  <= 32'd0;
            st_cnt_r  <= 32'd0;
            stl_cnt_r <= 32'd0;
        end else begin
            if (ld_inc_i)  ld_cnt_r  <= ld_cnt_r  + 32'd1;
            if (st_inc_i)  st_cnt_r  <= st_cnt_r  + 32'd1;
            if (stl_inc_i) stl_cnt_r <= stl_cnt_r + 32'd1;
        end
    end

    assign ld_cnt_o  = ld_cnt_r;
    assign st_cnt_o  = st_cnt_r;
    assign stl_cnt_o = stl_cnt_r;

endmodule

// File: rtl/dmem_access.sv
// Memory-access stage between EX and WB driving one synchronous 1-cycle-latency RAM port.
// Define VENUS_DMEM_STATS_EN to add the ld/st/stall event counter outputs.
module dmem_access
    import dmem_access_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              v_i,
    output logic              stall_o,
    input  logic              wb_i,
    input  logic [W_RD-1:0]   rd_num_i,
    input  logic [WORD-1:0]   rd_data_i,
    input  logic [W_MOP-1:0]  mop_i,
    input  logic [ADDR-1:0]   maddr_i,
    output logic [ADDR-1:0]   mem_a_o,
    output logic              mem_w_o,
    output logic [WORD-1:0]   mem_d_o,
    input  logic [WORD-1:0]   mem_q_i,
    output logic              v_o,
    input  logic              stall_i,
    output logic              wb_o,
    output logic [W_RD-1:0]   rd_num_o,
    output logic [WORD-1:0]   rd_data_o
`ifdef VENUS_DMEM_STATS_EN
    ,
    output logic [31:0]       ld_cnt_o,
    output logic [31:0]       st_cnt_o,
    output logic [31:0]       stl_cnt_o
`endif
);

    state_e          state_r;
    state_e          state_nxt_s;
    mop_e            mop_s;
    logic            stall_s;
    logic            accept_s;
    logic            out_free_s;
    logic            out_ld_s;
    out_sel_e        out_sel_s;
    logic            pend_ld_s;
    logic            buf_ld_s;
    wb_payload_t     out_nxt_s;
    wb_payload_t     out_r;
    logic            v_o_r;
    logic            pend_wb_r;
    logic [W_RD-1:0] pend_rd_r;
    logic [WORD-1:0] buf_r;

    assign mop_s      = decode_mop(mop_i);
    assign stall_s    = ~rst | (state_r != ST_IDLE) | (v_o_r & stall_i);
    assign accept_s   = v_i & ~stall_s;
    // The output register can take new data when it is empty or being drained this cycle.
    assign out_free_s = ~v_o_r | ~stall_i;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (mop_s == MOP_LOAD)) begin
                    state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (out_free_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RDHOLD;
                end
            end
            ST_RDHOLD: begin
                if (out_free_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RDHOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: memory port strobes and datapath load enables.
    always_comb begin
        stall_o   = stall_s;
        mem_a_o   = maddr_i;
        mem_d_o   = rd_data_i;
        mem_w_o   = 1'b0;
        out_ld_s  = 1'b0;
        out_sel_s = SEL_IN;
        pend_ld_s = 1'b0;
        buf_ld_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (mop_s)
                        MOP_LOAD: begin
                            pend_ld_s = 1'b1;
                        end
                        MOP_STORE: begin
                            mem_w_o  = 1'b1;
                            out_ld_s = 1'b1;
                        end
                        default: begin
                            out_ld_s = 1'b1;
                        end
                    endcase
                end else begin
                    mem_w_o = 1'b0;
                end
            end
            ST_RD: begin
                // mem_q_i is only valid now, so it is either consumed or buffered here.
                if (out_free_s) begin
                    out_ld_s  = 1'b1;
                    out_sel_s = SEL_Q;
                end else begin
                    buf_ld_s = 1'b1;
                end
            end
            ST_RDHOLD: begin
                if (out_free_s) begin
                    out_ld_s  = 1'b1;
                    out_sel_s = SEL_BUF;
                end else begin
                    out_ld_s = 1'b0;
                end
            end
            default: begin
                out_ld_s = 1'b0;
            end
        endcase
    end

    // Output register source select.
    always_comb begin
        out_nxt_s = '{wb: wb_i, rd_num: rd_num_i, rd_data: rd_data_i};
        case (out_sel_s)
            SEL_Q:   out_nxt_s = '{wb: pend_wb_r, rd_num: pend_rd_r, rd_data: mem_q_i};
            SEL_BUF: out_nxt_s = '{wb: pend_wb_r, rd_num: pend_rd_r, rd_data: buf_r};
            default: out_nxt_s = '{wb: wb_i, rd_num: rd_num_i, rd_data: rd_data_i};
        endcase
    end

    // Output register, pending-load fields and load data buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_o_r     <= 1'b0;
            out_r     <= '0;
            pend_wb_r <= 1'b0;
            pend_rd_r <= '0;
            buf_r     <= '0;
        end else begin
            if (out_ld_s) begin
                v_o_r <= 1'b1;
                out_r <= out_nxt_s;
            end else if (v_o_r && !stall_i) begin
                v_o_r <= 1'b0;
            end
            if (pend_ld_s) begin
                pend_wb_r <= wb_i;
                pend_rd_r <= rd_num_i;
            end
            if (buf_ld_s) begin
                buf_r <= mem_q_i;
            end
        end
    end

    assign v_o       = v_o_r;
    assign wb_o      = out_r.wb;
    assign rd_num_o  = out_r.rd_num;
    assign rd_data_o = out_r.rd_data;

`ifdef VENUS_DMEM_STATS_EN
    dmem_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .ld_inc_i  (accept_s & (mop_s == MOP_LOAD)),
        .st_inc_i  (accept_s & (mop_s == MOP_STORE)),
        .stl_inc_i (v_i & stall_s),
        .ld_cnt_o  (ld_cnt_o),
        .st_cnt_o  (st_cnt_o),
        .stl_cnt_o (stl_cnt_o)
    );
`endif

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: directed scenarios plus a randomized run scored
// against an in-order transaction queue and a reference memory image.
module tb_dmem_access;
    import dmem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v_i = 1'b0;
    logic        stall_o;
    logic        wb_i = 1'b0;
    logic [4:0]  rd_num_i = 5'd0;
    logic [31:0] rd_data_i = 32'd0;
    logic [1:0]  mop_i = 2'd0;
    logic [15:0] maddr_i = 16'd0;
    logic [15:0] mem_a_o;
    logic        mem_w_o;
    logic [31:0] mem_d_o;
    logic [31:0] mem_q_i = 32'd0;
    logic        v_o;
    logic        stall_i = 1'b0;
    logic        wb_o;
    logic [4:0]  rd_num_o;
    logic [31:0] rd_data_o;
`ifdef VENUS_DMEM_STATS_EN
    logic [31:0] ld_cnt, st_cnt, stl_cnt;
`endif

    dmem_access dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .wb_i(wb_i),
        .rd_num_i(rd_num_i), .rd_data_i(rd_data_i), .mop_i(mop_i), .maddr_i(maddr_i),
        .mem_a_o(mem_a_o), .mem_w_o(mem_w_o), .mem_d_o(mem_d_o), .mem_q_i(mem_q_i),
        .v_o(v_o), .stall_i(stall_i), .wb_o(wb_o), .rd_num_o(rd_num_o), .rd_data_o(rd_data_o)
`ifdef VENUS_DMEM_STATS_EN
        , .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt), .stl_cnt_o(stl_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] d;
    } exp_t;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [31:0] fix_mem [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic        acc_seen = 1'b0;
    logic        hold_prev = 1'b0;
    exp_t        prev_out;
    int          m_ld = 0, m_st = 0, m_stl = 0, n_acc = 0;

    function automatic logic [31:0] seed_word(input int a);
        return 32'(a) * 32'h9E37_79B1 + 32'h0000_1357;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM stand-in driven by the DUT port (read-before-write).
    always @(posedge clk) begin
        if (mem_w_o) fix_mem[mem_a_o] <= mem_d_o;
        mem_q_i <= fix_mem[mem_a_o];
    end

    // Scoreboard: every accepted EX transfer must reappear once, in order, at WB.
    always @(negedge clk) begin
        exp_t e;
        logic acc;
        if (!rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
            acc_seen  = 1'b0;
            m_ld = 0; m_st = 0; m_stl = 0;
        end else begin
            if (hold_prev) begin
                chk("hold_v", {31'd0, v_o}, 32'd1);
                chk("hold_fields", {26'd0, wb_o, rd_num_o} ^ rd_data_o,
                    {26'd0, prev_out.wb, prev_out.rd} ^ prev_out.d);
            end
            if (v_o && !stall_i) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_wb", {31'd0, wb_o}, {31'd0, e.wb});
                    chk("out_rd", {27'd0, rd_num_o}, {27'd0, e.rd});
                    chk("out_data", rd_data_o, e.d);
                end
            end
            if (v_o && stall_i) chk("stall_back", {31'd0, stall_o}, 32'd1);
            acc = v_i & ~stall_o;
            if (acc) begin
                n_acc++;
                if (mop_i == 2'd2) begin
                    chk("st_w", {31'd0, mem_w_o}, 32'd1);
                    chk("st_a", {16'd0, mem_a_o}, {16'd0, maddr_i});
                    chk("st_d", mem_d_o, rd_data_i);
                    ref_mem[maddr_i] = rd_data_i;
                    exp_q.push_back('{wb: wb_i, rd: rd_num_i, d: rd_data_i});
                    m_st++;
                end else if (mop_i == 2'd1) begin
                    chk("ld_w", {31'd0, mem_w_o}, 32'd0);
                    chk("ld_a", {16'd0, mem_a_o}, {16'd0, maddr_i});
                    exp_q.push_back('{wb: wb_i, rd: rd_num_i, d: ref_mem[maddr_i]});
                    m_ld++;
                end else begin
                    chk("none_w", {31'd0, mem_w_o}, 32'd0);
                    exp_q.push_back('{wb: wb_i, rd: rd_num_i, d: rd_data_i});
                end
            end else begin
                chk("idle_w", {31'd0, mem_w_o}, 32'd0);
            end
            if (v_i && stall_o) m_stl++;
            hold_prev = v_o & stall_i;
            prev_out  = '{wb: wb_o, rd: rd_num_o, d: rd_data_o};
            acc_seen  = acc;
        end
    end

    task automatic drv(input logic v, input logic [1:0] m, input logic [15:0] a,
                       input logic [31:0] d, input logic w, input logic [4:0] r);
        v_i = v; mop_i = m; maddr_i = a; rd_data_i = d; wb_i = w; rd_num_i = r;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            fix_mem[i] = seed_word(i);
            ref_mem[i] = seed_word(i);
        end
        // Reset values.
        #12;
        chk("rst_v", {31'd0, v_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd1);
        chk("rst_w", {31'd0, mem_w_o}, 32'd0);
        chk("rst_rd", {27'd0, rd_num_o}, 32'd0);
        chk("rst_data", rd_data_o, 32'd0);
        #11 rst = 1'b1;

        // Back-to-back pass-through stream.
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i <= 4) drv(1'b1, 2'd0, 16'd0, 32'(i), 1'b1, 5'(i));
            else        drv(1'b0, 2'd0, 16'd0, 32'd0, 1'b0, 5'd0);
            #1;
            if (i <= 4) chk("none_stall", {31'd0, stall_o}, 32'd0);
            if (i >= 2) begin
                chk("none_v", {31'd0, v_o}, 32'd1);
                chk("none_data", rd_data_o, 32'(i - 1));
            end
        end

        // Store then load-back.
        step();
        drv(1'b1, 2'd2, 16'h0010, 32'hDEAD_BEEF, 1'b0, 5'd0);
        #1;
        chk("store_w", {31'd0, mem_w_o}, 32'd1);
        chk("store_a", {16'd0, mem_a_o}, 32'h0000_0010);
        chk("store_d", mem_d_o, 32'hDEAD_BEEF);
        step();
        drv(1'b1, 2'd1, 16'h0010, 32'd0, 1'b1, 5'd5);
        #1;
        chk("store_v_next", {31'd0, v_o}, 32'd1);
        chk("load_acc", {31'd0, stall_o}, 32'd0);
        step();
        drv(1'b0, 2'd0, 16'd0, 32'd0, 1'b0, 5'd0);
        #1;
        chk("load_busy", {31'd0, stall_o}, 32'd1);
        chk("load_v1", {31'd0, v_o}, 32'd0);
        step();
        #1;
        chk("load_v2", {31'd0, v_o}, 32'd1);
        chk("load_data", rd_data_o, 32'hDEAD_BEEF);
        chk("load_rd", {27'd0, rd_num_o}, 32'd5);

        // Load while WB stalls for three cycles.
        step();
        drv(1'b1, 2'd1, 16'h0010, 32'd0, 1'b1, 5'd7);
        step();
        drv(1'b0, 2'd0, 16'd0, 32'd0, 1'b0, 5'd0);
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            #1;
            chk("ldst_v", {31'd0, v_o}, 32'd1);
            chk("ldst_data", rd_data_o, 32'hDEAD_BEEF);
            chk("ldst_stall", {31'd0, stall_o}, 32'd1);
        end
        step();
        stall_i = 1'b0;
        #1;
        chk("ldst_rel_v", {31'd0, v_o}, 32'd1);
        chk("ldst_rel_rd", {27'd0, rd_num_o}, 32'd7);
        step();
        #1;
        chk("ldst_nodup", {31'd0, v_o}, 32'd0);

        // Asynchronous reset in the middle of a load.
        step();
        drv(1'b1, 2'd1, 16'h0020, 32'd0, 1'b1, 5'd9);
        step();
        drv(1'b1, 2'd2, 16'h0030, 32'h0000_1234, 1'b0, 5'd0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_v", {31'd0, v_o}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall_o}, 32'd1);
        chk("mid_rst_w", {31'd0, mem_w_o}, 32'd0);
        step();
        step();
        drv(1'b0, 2'd0, 16'd0, 32'd0, 1'b0, 5'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, stall_o}, 32'd0);
        chk("post_rst_v", {31'd0, v_o}, 32'd0);
        step();
        drv(1'b1, 2'd3, 16'd0, 32'h0000_0055, 1'b1, 5'd3);
        step();
        drv(1'b0, 2'd0, 16'd0, 32'd0, 1'b0, 5'd0);
        #1;
        chk("post_rst_none", rd_data_o, 32'h0000_0055);

`ifdef VENUS_DMEM_STATS_EN
        // Counter scenario: two loads, one store, three held-off cycles.
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        drv(1'b1, 2'd1, 16'h0010, 32'd0, 1'b1, 5'd1);
        step();
        drv(1'b1, 2'd1, 16'h0014, 32'd0, 1'b1, 5'd2);
        step();
        step();
        drv(1'b1, 2'd2, 16'h0018, 32'h0000_00AA, 1'b0, 5'd0);
        step();
        step();
        drv(1'b1, 2'd0, 16'd0, 32'h0000_00BB, 1'b1, 5'd4);
        stall_i = 1'b1;
        step();
        stall_i = 1'b0;
        step();
        drv(1'b0, 2'd0, 16'd0, 32'd0, 1'b0, 5'd0);
        step();
        step();
        chk("stat_ld", ld_cnt, 32'd2);
        chk("stat_st", st_cnt, 32'd1);
        chk("stat_stl", stl_cnt, 32'd3);
`endif

        // Randomized traffic with handshake-respecting producer and random WB stalls.
        n_acc = 0;
        for (int c = 0; c < 2000; c++) begin
            step();
            if (!v_i || acc_seen) begin
                drv(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    16'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)));
            end
            stall_i = ($urandom_range(0, 3) == 0);
        end
        step();
        if (!acc_seen && v_i) begin
            @(negedge clk);
            step();
        end
        drv(1'b0, 2'd0, 16'd0, 32'd0, 1'b0, 5'd0);
        stall_i = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        step();
        step();
        chk("drained", exp_q.size(), 32'd0);
        chk("throughput", {31'd0, (n_acc > 500)}, 32'd1);
`ifdef VENUS_DMEM_STATS_EN
        chk("rand_ld", ld_cnt, m_ld);
        chk("rand_st", st_cnt, m_st);
        chk("rand_stl", stl_cnt, m_stl);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
